// File: rtl/cordic_rot_pkg.sv
// cordic_rot_pkg: shared FSM state, output gain constant and quadrant codes for the CORDIC rotation engine
package cordic_rot_pkg;
  typedef enum logic [1:0] {IDLE, ROTATE, OUTPUT} state_t;
  localparam real K_SCALE = 0.6072529;
  localparam logic [1:0] Q_POS = 2'b00, Q_NEG = 2'b01, Q_PI_NEG = 2'b10, Q_NEG_PI = 2'b11;
endpackage

// File: rtl/cordic_rotation_iter_if.sv
// cordic_rotation_iter_if: request/result bundle of the CORDIC rotation engine
// master drives rot_en, x/y_rot_in, micro_angle_in, quad_in; slave drives in_ready, x/y_rot_out, output_valid_o
interface cordic_rotation_iter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CORDIC_STAGES = 16
);
  logic rot_en, in_ready, output_valid_o;
  logic signed [DATA_WIDTH-1:0] x_rot_in, y_rot_in, x_rot_out, y_rot_out;
  logic [CORDIC_STAGES-1:0] micro_angle_in;
  logic [1:0] quad_in;
  modport master (
    output rot_en, x_rot_in, y_rot_in, micro_angle_in, quad_in,
    input in_ready, x_rot_out, y_rot_out, output_valid_o
  );
  modport slave (
    input rot_en, x_rot_in, y_rot_in, micro_angle_in, quad_in,
    output in_ready, x_rot_out, y_rot_out, output_valid_o
  );
endinterface

// File: rtl/cordic_rot_out_conv.sv
// cordic_rot_out_conv: optional gain compensation, round-half-up and saturation of one CORDIC lane
// din: CORDIC_WIDTH internal value; dout: DATA_WIDTH saturated result; CORDIC_ROT_SCALE_EN enables the K multiply
module cordic_rot_out_conv
  import cordic_rot_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CORDIC_WIDTH = 22
) (
  input  logic signed [CORDIC_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0]   dout
);
  localparam int FB = CORDIC_WIDTH - DATA_WIDTH - 2;
`ifdef CORDIC_ROT_SCALE_EN
  localparam int PW = 2 * CORDIC_WIDTH;
  localparam int SH = FB + CORDIC_WIDTH - 2;
  localparam logic signed [CORDIC_WIDTH-1:0] K = CORDIC_WIDTH'($rtoi(K_SCALE * (2.0 ** (CORDIC_WIDTH - 2)) + 0.5));
  logic signed [PW-1:0] full;
  assign full = PW'(din) * PW'(K);
`else
  localparam int PW = CORDIC_WIDTH + 1;
  localparam int SH = FB;
  logic signed [PW-1:0] full;
  assign full = PW'(din);
`endif
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (SH - 1);
  localparam logic signed [PW-1:0] MAXV = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
  logic signed [PW-1:0] rnd;
  assign rnd = (full + HALF) >>> SH;
  assign dout = rnd > MAXV ? MAXV[DATA_WIDTH-1:0] : rnd < MINV ? MINV[DATA_WIDTH-1:0] : rnd[DATA_WIDTH-1:0];
endmodule

// File: rtl/cordic_rotation_iter.sv
// cordic_rotation_iter: iterative CORDIC rotation engine, one micro-rotation per clock
// clk, nreset (sync active-low); bus (slave): rot_en/in_ready accept, x/y_rot_in, micro_angle_in, quad_in,
// x/y_rot_out held results, output_valid_o one-cycle pulse; CORDIC_ROT_SCALE_EN removes the CORDIC gain
module cordic_rotation_iter
  import cordic_rot_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CORDIC_WIDTH = 22,
  parameter int CORDIC_STAGES = 16
) (
  input logic clk,
  input logic nreset,
  cordic_rotation_iter_if.slave bus
);
  localparam int FB = CORDIC_WIDTH - DATA_WIDTH - 2;
  localparam int CNTW = $clog2(CORDIC_STAGES);
  state_t state, state_n;
  logic [CNTW-1:0] cnt;
  logic signed [CORDIC_WIDTH-1:0] x, y, x_ext, y_ext, x_nx, y_nx;
  logic [CORDIC_STAGES-1:0] ang;
  logic neg, d_pos, acc, valid;
  logic signed [DATA_WIDTH-1:0] x_out, y_out, x_cv, y_cv;
  assign acc = state == IDLE && bus.rot_en;
  assign x_ext = CORDIC_WIDTH'(bus.x_rot_in) <<< FB;
  assign y_ext = CORDIC_WIDTH'(bus.y_rot_in) <<< FB;
  assign d_pos = ang[cnt] ^ neg;
  always_comb begin
    x_nx = d_pos ? x - (y >>> cnt) : x + (y >>> cnt);
    y_nx = d_pos ? y + (x >>> cnt) : y - (x >>> cnt);
    state_n = state == IDLE ? (bus.rot_en ? ROTATE : IDLE) :
              state == ROTATE ? (cnt == CNTW'(CORDIC_STAGES - 1) ? OUTPUT : ROTATE) : IDLE;
  end
  always_ff @(posedge clk)
    if (!nreset) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      ang <= '0;
      neg <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      valid <= state == OUTPUT;
      if (acc) begin
        x <= bus.quad_in[1] ? -x_ext : x_ext;
        y <= bus.quad_in[1] ? -y_ext : y_ext;
        ang <= bus.micro_angle_in;
        neg <= bus.quad_in == Q_NEG || bus.quad_in == Q_PI_NEG;
        cnt <= '0;
      end
      if (state == ROTATE) begin
        x <= x_nx;
        y <= y_nx;
        cnt <= cnt + CNTW'(1);
      end
      if (state == OUTPUT) begin
        x_out <= x_cv;
        y_out <= y_cv;
      end
    end
  cordic_rot_out_conv #(.DATA_WIDTH(DATA_WIDTH), .CORDIC_WIDTH(CORDIC_WIDTH)) u_conv_x (.din(x), .dout(x_cv));
  cordic_rot_out_conv #(.DATA_WIDTH(DATA_WIDTH), .CORDIC_WIDTH(CORDIC_WIDTH)) u_conv_y (.din(y), .dout(y_cv));
  assign bus.in_ready = state == IDLE;
  assign bus.x_rot_out = x_out;
  assign bus.y_rot_out = y_out;
  assign bus.output_valid_o = valid;
endmodule

// File: tb/tb_cordic_rotation_iter.sv
// tb_cordic_rotation_iter: scoreboard bench for cordic_rotation_iter against a real-arithmetic rotation model
module tb_cordic_rotation_iter;
`ifdef CORDIC_ROT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  localparam int LAT = 18;
  typedef struct {int due; int ex; int ey; int tol;} exp_t;
  logic clk = 1'b0, nreset = 1'b0;
  int cyc = 0, free_at = 0, checks = 0, errors = 0;
  int mode = 0, tx = 0, ty = 0, ttol = 0;
  exp_t sb[$];
  cordic_rotation_iter_if #(.DATA_WIDTH(16), .CORDIC_STAGES(16)) bus();
  cordic_rotation_iter #(.DATA_WIDTH(16), .CORDIC_WIDTH(22), .CORDIC_STAGES(16)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic int sat(input real v);
    real r;
    r = $floor(v + 0.5);
    return r > 32767.0 ? 32767 : r < -32768.0 ? -32768 : int'(r);
  endfunction
  function automatic void model(input int xi, input int yi, input logic [15:0] b, input logic [1:0] q,
                                output int ex, output int ey);
    real xr, yr, th, g;
    xr = q[1] ? -$itor(xi) : $itor(xi);
    yr = q[1] ? -$itor(yi) : $itor(yi);
    th = 0.0;
    g = SCALE ? 0.6072529 : 1.0;
    for (int i = 0; i < 16; i++) begin
      th += (((q[1] == q[0]) == b[i]) ? 1.0 : -1.0) * $atan(2.0 ** (-i));
      g *= $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    ex = sat(g * (xr * $cos(th) - yr * $sin(th)));
    ey = sat(g * (xr * $sin(th) + yr * $cos(th)));
  endfunction
  function automatic void vec(input int x, input int y, output logic [15:0] b, output logic [1:0] q, output int m);
    real ax, ay, t, nx;
    ax = x < 0 ? -$itor(x) : $itor(x);
    ay = y < 0 ? -$itor(y) : $itor(y);
    q = {x < 0, y < 0};
    for (int i = 0; i < 16; i++) begin
      t = 2.0 ** (-i);
      b[i] = ay >= 0.0;
      nx = b[i] ? ax + ay * t : ax - ay * t;
      ay = b[i] ? ay - ax * t : ay + ax * t;
      ax = nx;
    end
    m = sat($sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y)));
  endfunction
  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      if (errors <= 20) $display("FAIL %s actual=%0d required=%0d tol=%0d cycle=%0d", name, act, exp, tol, cyc);
    end
  endtask
  task automatic garbage();
    bus.x_rot_in = 16'($urandom);
    bus.y_rot_in = 16'($urandom);
    bus.micro_angle_in = 16'($urandom);
    bus.quad_in = 2'($urandom);
  endtask
  task automatic send(input int x, input int y, input logic [15:0] b, input logic [1:0] q,
                      input int md, input int mx, input int my, input int mt);
    while (cyc < free_at) @(negedge clk);
    bus.x_rot_in = 16'(x);
    bus.y_rot_in = 16'(y);
    bus.micro_angle_in = b;
    bus.quad_in = q;
    mode = md;
    tx = mx;
    ty = my;
    ttol = mt;
    bus.rot_en = 1'b1;
    @(negedge clk);
    bus.rot_en = 1'b0;
    mode = 0;
    garbage();
  endtask
  task automatic noise(input int n);
    repeat (n) begin
      @(negedge clk);
      garbage();
      bus.rot_en = cyc < free_at ? 1'($urandom % 2) : 1'b0;
    end
    bus.rot_en = 1'b0;
  endtask
  always @(posedge clk) begin
    if (!nreset) begin
      sb.delete();
      free_at = cyc + 1;
    end else if (bus.rot_en && cyc >= free_at) begin : pred
      exp_t e;
      e.due = cyc + LAT;
      if (mode == 2 || (mode == 1 && SCALE)) begin
        e.ex = tx;
        e.ey = ty;
        e.tol = ttol;
      end else begin
        model(int'(bus.x_rot_in), int'(bus.y_rot_in), bus.micro_angle_in, bus.quad_in, e.ex, e.ey);
        e.tol = 3;
      end
      sb.push_back(e);
      free_at = cyc + LAT;
    end
    cyc++;
  end
  always @(negedge clk) if (cyc > 0) begin : mon
    exp_t e;
    chk("in_ready", int'(bus.in_ready), int'(cyc >= free_at), 0);
    if (bus.output_valid_o) begin
      if (sb.size() == 0) chk("spurious_valid", int'(bus.output_valid_o), 0, 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due, 0);
        chk("x_rot_out", int'(bus.x_rot_out), e.ex, e.tol);
        chk("y_rot_out", int'(bus.y_rot_out), e.ey, e.tol);
      end
    end else if (sb.size() != 0 && cyc >= sb[0].due) begin
      void'(sb.pop_front());
      chk("missing_valid", int'(bus.output_valid_o), 1, 0);
    end
  end
  initial begin
    logic [15:0] b;
    logic [1:0] q;
    int m, x, y, acc, n;
    bus.rot_en = 1'b0;
    garbage();
    repeat (3) @(negedge clk);
    chk("rst_x", int'(bus.x_rot_out), 0, 0);
    chk("rst_y", int'(bus.y_rot_out), 0, 0);
    chk("rst_valid", int'(bus.output_valid_o), 0, 0);
    chk("rst_ready", int'(bus.in_ready), 1, 0);
    nreset = 1'b1;
    vec(16384, 16384, b, q, m);
    for (int k = 0; k < 4; k++)
      send(16384, 0, b, 2'(k), 1, k[1] ? -11585 : 11585, k[0] ? -11585 : 11585, 4);
    send(0, 0, 16'($urandom), 2'($urandom), 2, 0, 0, 0);
    send(0, 0, 16'($urandom), 2'($urandom), 2, 0, 0, 0);
    send(32767, 0, 16'h0000, 2'b00, 0, 0, 0, 0);
    vec(32767, 0, b, q, m);
    send(32767, 0, b, 2'b00, 0, 0, 0, 0);
    send(-32768, -32768, 16'($urandom), 2'b11, 0, 0, 0, 0);
    send(-32768, 12345, 16'($urandom), 2'b10, 0, 0, 0, 0);
    while (cyc < free_at) @(negedge clk);
    acc = 0;
    bus.rot_en = 1'b1;
    while (acc < 3) begin
      garbage();
      if (cyc >= free_at) acc++;
      @(negedge clk);
    end
    bus.rot_en = 1'b0;
    send(20000, 5000, 16'($urandom), 2'b00, 0, 0, 0, 0);
    send(16384, 0, 16'($urandom), 2'b00, 0, 0, 0, 0);
    repeat (7) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    chk("abort_x", int'(bus.x_rot_out), 0, 0);
    chk("abort_y", int'(bus.y_rot_out), 0, 0);
    chk("abort_valid", int'(bus.output_valid_o), 0, 0);
    chk("abort_ready", int'(bus.in_ready), 1, 0);
    noise(25);
    send(16384, 0, b, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      send(int'(16'($urandom)) - 32768, int'(16'($urandom)) - 32768, 16'($urandom), 2'($urandom), 0, 0, 0, 0);
      noise($urandom_range(0, 24));
    end
    for (int k = 0; k < 1000; k++) begin
      x = $urandom_range(0, 46000) - 23000;
      y = $urandom_range(0, 46000) - 23000;
      vec(x, y, b, q, m);
      send(m, 0, b, q, 1, x, y, 6);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
